mem_access_unit: RTL and testbench

//  Load/store initiator between the RV32I core and the project zero-delay RAM.
//  - Accepts one load/store request at a time from the core.
//  - Loads: extracts LB/LH/LW/LBU/LHU results with sign/zero extension.
//  - Word stores: single write. Byte/half stores: read-modify-write, because
//    the RAM only reads and writes 4-byte words.

---
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store initiator for the zero-delay word RAM.
// Optional misalignment trap: define MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
   parameter int dataW = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [2:0]       req_funct3,
   input  logic [dataW-1:0] req_addr,
   input  logic [dataW-1:0] req_wdata,
   output logic             rsp_valid,
   output logic [dataW-1:0] rsp_rdata,
   output logic             rsp_error,
   output logic [dataW-1:0] mem_addr,
   output logic [dataW-1:0] mem_wdata,
   output logic             mem_we,
   input  logic [dataW-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_RD,
      WRITE,
      RESP
   } state_t;

   state_t           state;
   state_t           nstate;
   logic             accept;
   logic             is_word;
   logic             misal;
   logic [2:0]       funct3_q;
   logic [dataW-1:0] addr_q;
   logic [dataW-1:0] wdata_q;
   logic [dataW-1:0] rdata_q;
   logic [dataW-1:0] load_ext;
   logic [dataW-1:0] merged;

   assign accept  = req_valid & req_ready;
   // funct3 x1x selects a full word (010, 011, 110, 111)
   assign is_word = req_funct3[1];

`ifdef MEM_MISALIGN_TRAP_EN
   logic err_q;

   // the RAM indexes words by their top byte address, so aligned means A[1:0]=11
   assign misal = (is_word & (req_addr[1:0] != 2'b11))
                | (~is_word & req_funct3[0] & ~req_addr[0]);

   // error flag follows the most recently accepted request
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         err_q <= 1'b0;
      else if (accept)
         err_q <= misal;
   end

   assign rsp_error = err_q;
`else
   assign misal     = 1'b0;
   assign rsp_error = 1'b0;
`endif

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= nstate;
   end

   // next-state selection
   always_comb begin
      nstate = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (misal)
                  nstate = RESP;
               else if (!req_write)
                  nstate = LOAD;
               else if (is_word)
                  nstate = WRITE;
               else
                  nstate = RMW_RD;
            end
         end
         LOAD:    nstate = RESP;
         RMW_RD:  nstate = WRITE;
         WRITE:   nstate = RESP;
         RESP:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // handshake and write strobe decoded from the state register
   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
      mem_we    = (state == WRITE);
   end

   // sign/zero extension of the RAM word for the latched load size
   always_comb begin
      load_ext = mem_rdata;
      unique case (funct3_q)
         3'b000: load_ext = {{(dataW-8){mem_rdata[7]}}, mem_rdata[7:0]};
         3'b001: load_ext = {{(dataW-16){mem_rdata[15]}}, mem_rdata[15:0]};
         3'b100: load_ext = {{(dataW-8){1'b0}}, mem_rdata[7:0]};
         3'b101: load_ext = {{(dataW-16){1'b0}}, mem_rdata[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   // sub-word store data merged into the old RAM word
   always_comb begin
      if (funct3_q[0])
         merged = {mem_rdata[dataW-1:16], wdata_q[15:0]};
      else
         merged = {mem_rdata[dataW-1:8], wdata_q[7:0]};
   end

   // request latch, load capture and read-modify-write capture
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         if (accept) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
         end
         if (state == LOAD)
            rdata_q <= load_ext;
         if (state == RMW_RD)
            wdata_q <= merged;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table, corner sequences and random
// traffic against a byte-array memory model.
module tb_mem_access_unit;

`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [7:0] ram [256];
   logic [7:0] ref_mem [256];
   logic       ram_clear;
   logic [7:0] ma;

   mem_access_unit #(.dataW(32)) dut (
      .clock(clock),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_funct3(req_funct3),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   // zero-delay RAM, aliased modulo 256 bytes
   assign ma = mem_addr[7:0];
   assign mem_rdata = {ram[ma-8'd3], ram[ma-8'd2], ram[ma-8'd1], ram[ma]};

   always @(posedge clock) begin
      if (ram_clear) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      end else if (mem_we) begin
         ram[ma]       <= mem_wdata[7:0];
         ram[ma-8'd1]  <= mem_wdata[15:8];
         ram[ma-8'd2]  <= mem_wdata[23:16];
         ram[ma-8'd3]  <= mem_wdata[31:24];
      end
   end

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          we;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      return f3[1] ? 4 : (f3[0] ? 2 : 1);
   endfunction

   function automatic bit misaligned(input logic [2:0] f3,
                                     input logic [31:0] a);
      int s;
      s = size_of(f3);
      return TRAP && ((s == 4 && a[1:0] != 2'b11) || (s == 2 && !a[0]));
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3,
                                              input logic [31:0] a);
      logic [7:0]  b [4];
      logic [31:0] v;
      for (int i = 0; i < 4; i++) b[i] = ref_mem[a[7:0] - 8'(i)];
      case (size_of(f3))
         1: v = f3[2] ? {24'h0, b[0]} : {{24{b[0][7]}}, b[0]};
         2: v = f3[2] ? {16'h0, b[1], b[0]} : {{16{b[1][7]}}, b[1], b[0]};
         default: v = {b[3], b[2], b[1], b[0]};
      endcase
      return v;
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d);
      for (int i = 0; i < size_of(f3); i++)
         ref_mem[a[7:0] - 8'(i)] = d[8*i +: 8];
   endtask

   // one request; called and returning #1 after a rising edge
   task automatic xact(input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er,
                       output int lat, output int wecnt);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got 0 expected 1");
      end
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat   = 0;
      wecnt = 0;
      rd    = '0;
      er    = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (mem_we) wecnt++;
         if (rsp_valid) begin
            lat = c;
            rd  = rsp_rdata;
            er  = rsp_error;
            break;
         end
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
   endtask

   task automatic run_check(input string name, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] erd,
                            input logic eer, input int elat, input int ewe);
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          wecnt;
      xact(wr, f3, a, d, rd, er, lat, wecnt);
      chk({name, "_rdata"}, rd, erd);
      chk({name, "_error"}, {31'h0, er}, {31'h0, eer});
      chk({name, "_latency"}, lat, elat);
      chk({name, "_we_cycles"}, wecnt, ewe);
      if (wr && !misaligned(f3, a)) model_store(f3, a, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f3;
      logic        wr;
      logic        er_e;
      logic [31:0] rd_e;
      int          lat_e;
      int          bad;
      int          idx;
      int          nrsp;
      int          outst;
      bit          acc;
      vec_t        bq [3];
      logic [31:0] expq [$];

      reset      = 1'b1;
      ram_clear  = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = '0;
      req_wdata  = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_error", {31'h0, rsp_error}, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      ram_clear = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;

      // asynchronous reset in the middle of a load
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h43;
      @(posedge clock); #1;
      req_valid = 1'b0;
      chk("mid_addr_latched", mem_addr, 32'h43);
      chk("mid_busy", {31'h0, req_ready}, 32'h0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_ready", {31'h0, req_ready}, 32'h1);
      chk("async_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("async_mem_we", {31'h0, mem_we}, 32'h0);
      chk("async_mem_addr", mem_addr, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;

      vt[0]  = '{1'b1, 3'b010, 32'h13, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1};
      vt[1]  = '{1'b0, 3'b010, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0};
      vt[2]  = '{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 0};
      vt[3]  = '{1'b0, 3'b100, 32'h13, 32'h0, 32'h000000EF, 1'b0, 2, 0};
      vt[4]  = '{1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0};
      vt[5]  = '{1'b0, 3'b101, 32'h13, 32'h0, 32'h0000BEEF, 1'b0, 2, 0};
      vt[6]  = '{1'b1, 3'b000, 32'h13, 32'h12345678, 32'h0, 1'b0, 3, 1};
      vt[7]  = '{1'b0, 3'b010, 32'h13, 32'h0, 32'hDEADBE78, 1'b0, 2, 0};
      vt[8]  = '{1'b1, 3'b001, 32'h13, 32'hAAAA5555, 32'h0, 1'b0, 3, 1};
      vt[9]  = '{1'b0, 3'b010, 32'h13, 32'h0, 32'hDEAD5555, 1'b0, 2, 0};
`ifdef MEM_MISALIGN_TRAP_EN
      vt[10] = '{1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0};
      vt[11] = '{1'b1, 3'b001, 32'h12, 32'h0000CAFE, 32'h0, 1'b1, 1, 0};
      vt[12] = '{1'b0, 3'b010, 32'h13, 32'h0, 32'hDEAD5555, 1'b0, 2, 0};
`else
      vt[10] = '{1'b0, 3'b010, 32'h12, 32'h0, 32'h00DEAD55, 1'b0, 2, 0};
      vt[11] = '{1'b1, 3'b001, 32'h12, 32'h0000CAFE, 32'h0, 1'b0, 3, 1};
      vt[12] = '{1'b0, 3'b010, 32'h13, 32'h0, 32'hDECAFE55, 1'b0, 2, 0};
`endif
      for (int i = 0; i < 13; i++)
         run_check($sformatf("vec%0d", i), vt[i].wr, vt[i].f3, vt[i].a,
                   vt[i].d, vt[i].rd, vt[i].er, vt[i].lat, vt[i].we);

      // three requests with req_valid held high
      bq[0] = '{1'b1, 3'b010, 32'h23, 32'h11223344, 32'h0, 1'b0, 0, 0};
      bq[1] = '{1'b0, 3'b010, 32'h23, 32'h0, 32'h0, 1'b0, 0, 0};
      bq[2] = '{1'b0, 3'b100, 32'h22, 32'h0, 32'h0, 1'b0, 0, 0};
      idx   = 0;
      nrsp  = 0;
      outst = 0;
      req_valid  = 1'b1;
      req_write  = bq[0].wr;
      req_funct3 = bq[0].f3;
      req_addr   = bq[0].a;
      req_wdata  = bq[0].d;
      for (int c = 0; c < 40 && nrsp < 3; c++) begin
         if (rsp_valid) begin
            if (expq.size() > 0) chk($sformatf("b2b_rdata%0d", nrsp),
                                     rsp_rdata, expq.pop_front());
            nrsp++;
            outst--;
         end
         acc = req_ready && idx < 3;
         if (acc) begin
            chk("b2b_no_overlap", outst, 0);
            if (bq[idx].wr) begin
               expq.push_back(32'h0);
               model_store(bq[idx].f3, bq[idx].a, bq[idx].d);
            end else begin
               expq.push_back(model_load(bq[idx].f3, bq[idx].a));
            end
            outst++;
         end
         @(posedge clock); #1;
         if (acc) begin
            idx++;
            if (idx < 3) begin
               req_write  = bq[idx].wr;
               req_funct3 = bq[idx].f3;
               req_addr   = bq[idx].a;
               req_wdata  = bq[idx].d;
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      chk("b2b_rsp_count", nrsp, 3);
      @(posedge clock); #1;

      // reset during the WRITE cycle of a word store
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h33;
      req_wdata  = 32'hCAFEF00D;
      @(posedge clock); #1;
      req_valid = 1'b0;
      chk("wr_reset_we_before", {31'h0, mem_we}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("wr_reset_we_drop", {31'h0, mem_we}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clock); #1;
         if (rsp_valid) bad++;
      end
      chk("wr_reset_no_rsp", bad, 0);
      run_check("wr_reset_mem", 1'b0, 3'b010, 32'h33, 32'h0,
                model_load(3'b010, 32'h33), 1'b0, 2, 0);

      // random traffic against the byte model
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         a[7:0] = 8'h10 + 8'($urandom_range(0, 15));
         d  = $urandom;
         er_e  = misaligned(f3, a);
         lat_e = er_e ? 1 : ((wr && size_of(f3) != 4) ? 3 : 2);
         rd_e  = (wr || er_e) ? 32'h0 : model_load(f3, a);
         run_check($sformatf("rnd%0d", i), wr, f3, a, d, rd_e, er_e,
                   lat_e, (wr && !er_e) ? 1 : 0);
      end

      bad = 0;
      for (int i = 0; i < 256; i++)
         if (ram[i] !== ref_mem[i]) bad++;
      chk("ram_image_mismatches", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
